// File: rtl/dispatch_ctrl.sv
// rtl/dispatch_ctrl.sv - in-order dispatch queue routing decoded instructions to the ALU or LSU
// Optional feature macro: DISPATCH_BYPASS_EN (empty-queue combinational bypass to the targets)
module dispatch_ctrl #(
   parameter int INSTR_WIDTH = 32,
   parameter int C_SIG_WIDTH = 7,
   parameter int DEPTH       = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INSTR_WIDTH-1:0] in_instr,
   input  logic [C_SIG_WIDTH-1:0] in_csig,
   output logic                   alu_valid,
   input  logic                   alu_ready,
   output logic                   lsu_valid,
   input  logic                   lsu_ready,
   output logic [INSTR_WIDTH-1:0] out_instr,
   output logic [C_SIG_WIDTH-1:0] out_csig,
   output logic [7:0]             drop_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {
      RT_DROP,
      RT_ALU,
      RT_LSU
   } route_t;

   // Memory-access bits win over everything; an all-zero control word carries no work.
   function automatic route_t route_of(input logic [C_SIG_WIDTH-1:0] c);
      if (c[3] | c[2])
         return RT_LSU;
      else if (c != '0)
         return RT_ALU;
      else
         return RT_DROP;
   endfunction

   logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
   logic [C_SIG_WIDTH-1:0] csig_mem  [DEPTH];
   logic [PW-1:0]          head;
   logic [PW-1:0]          tail;
   logic [PW:0]            count;

   logic                   empty;
   logic                   sel_live;
   logic [INSTR_WIDTH-1:0] sel_instr;
   logic [C_SIG_WIDTH-1:0] sel_csig;
   route_t                 rt;
   logic                   take;
   logic                   q_pop;
   logic                   byp_take;
   logic                   push;
   logic                   drop_evt;

   assign empty    = (count == '0);
   // in_ready looks only at registered occupancy so a full queue never accepts on a pop cycle.
   assign in_ready = (count != FULL) && !flush;

   // Select what is presented to the targets: the head entry, or the incoming entry on bypass.
   always_comb begin
      sel_instr = instr_mem[head];
      sel_csig  = csig_mem[head];
      sel_live  = !empty;
`ifdef DISPATCH_BYPASS_EN
      if (empty) begin
         sel_instr = in_instr;
         sel_csig  = in_csig;
         sel_live  = in_valid && !flush;
      end
`endif
   end

   // Route the presented entry and decide whether it leaves this cycle.
   always_comb begin
      rt        = route_of(sel_csig);
      alu_valid = sel_live && (rt == RT_ALU);
      lsu_valid = sel_live && (rt == RT_LSU);
      drop_evt  = sel_live && (rt == RT_DROP);
      take      = drop_evt || (alu_valid && alu_ready) || (lsu_valid && lsu_ready);
      q_pop     = take && !empty;
      byp_take  = take && empty;
      push      = in_valid && in_ready && !byp_take;
      out_instr = sel_instr;
      out_csig  = sel_csig;
   end

   // Pointer, occupancy and drop-counter bookkeeping; flush clears the queue but keeps drop_cnt.
   always_ff @(posedge clk) begin
      if (rst) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         drop_cnt <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push)
            tail <= tail + PW'(1);
         if (q_pop)
            head <= head + PW'(1);
         if (push && !q_pop)
            count <= count + (PW+1)'(1);
         else if (!push && q_pop)
            count <= count - (PW+1)'(1);
         if (drop_evt && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'd1;
      end
   end

   // Entry storage is written at the tail and never cleared.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         instr_mem[tail] <= in_instr;
         csig_mem[tail]  <= in_csig;
      end
   end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb/tb_dispatch_ctrl.sv - self-checking bench for dispatch_ctrl with a queue-based reference model
module tb_dispatch_ctrl;

   localparam int IW    = 32;
   localparam int CW    = 7;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, alu_ready, lsu_ready;
   logic [IW-1:0] in_instr;
   logic [CW-1:0] in_csig;
   logic          in_ready, alu_valid, lsu_valid;
   logic [IW-1:0] out_instr;
   logic [CW-1:0] out_csig;
   logic [7:0]    drop_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [IW-1:0] i;
      logic [CW-1:0] c;
   } ent_t;

   ent_t mq[$];
   int   mdrop;

   dispatch_ctrl #(.INSTR_WIDTH(IW), .C_SIG_WIDTH(CW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_csig(in_csig),
      .alu_valid(alu_valid), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
      .out_instr(out_instr), .out_csig(out_csig), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   // 0 = drop, 1 = ALU, 2 = LSU
   function automatic int route(input logic [CW-1:0] c);
      if (c[3] || c[2]) return 2;
      if (c != 0) return 1;
      return 0;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_csig = '0;
      alu_ready = 1'b0; lsu_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      sample();
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
      n_checks++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_alu_valid: got %0b expected 0", alu_valid); end
      n_checks++; if (lsu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_lsu_valid: got %0b expected 0", lsu_valid); end
      n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
      next_cycle();
   endtask

   task automatic test_alu_dispatch();
      do_reset();
      in_valid = 1'b1; in_instr = 32'h0000_00A1; in_csig = 7'b1000000; alu_ready = 1'b1;
      sample();
`ifdef DISPATCH_BYPASS_EN
      n_checks++; if (alu_valid !== 1'b1) begin n_fail++; $display("FAIL alu_bypass_valid: got %0b expected 1", alu_valid); end
      next_cycle();
      in_valid = 1'b0;
`else
      n_checks++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL alu_no_comb_path: got %0b expected 0", alu_valid); end
      next_cycle();
      in_valid = 1'b0;
      sample();
      n_checks++; if (alu_valid !== 1'b1) begin n_fail++; $display("FAIL alu_next_cycle_valid: got %0b expected 1", alu_valid); end
      n_checks++; if (out_instr !== 32'h0000_00A1) begin n_fail++; $display("FAIL alu_out_instr: got %0h expected a1", out_instr); end
      n_checks++; if (lsu_valid !== 1'b0) begin n_fail++; $display("FAIL alu_lsu_quiet: got %0b expected 0", lsu_valid); end
      next_cycle();
`endif
      sample();
      n_checks++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL alu_after_pop: got %0b expected 0", alu_valid); end
      n_checks++; if (dut.count !== 3'd0) begin n_fail++; $display("FAIL alu_count_zero: got %0d expected 0", dut.count); end
      next_cycle();
   endtask

   task automatic test_order();
      do_reset();
      alu_ready = 1'b1; lsu_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h0000_1111; in_csig = 7'b1101010;
      next_cycle();
      in_instr = 32'h0000_2222; in_csig = 7'b1000000;
      next_cycle();
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sample();
         n_checks++; if (lsu_valid !== 1'b1 || alu_valid !== 1'b0 || out_instr !== 32'h0000_1111) begin
            n_fail++; $display("FAIL order_stall_%0d: got lsu=%0b alu=%0b instr=%0h expected lsu=1 alu=0 instr=1111", k, lsu_valid, alu_valid, out_instr);
         end
         next_cycle();
      end
      lsu_ready = 1'b1;
      sample();
      n_checks++; if (lsu_valid !== 1'b1 || out_instr !== 32'h0000_1111) begin n_fail++; $display("FAIL order_first: got lsu=%0b instr=%0h expected 1/1111", lsu_valid, out_instr); end
      next_cycle();
      sample();
      n_checks++; if (alu_valid !== 1'b1 || lsu_valid !== 1'b0 || out_instr !== 32'h0000_2222) begin
         n_fail++; $display("FAIL order_second: got alu=%0b lsu=%0b instr=%0h expected 1/0/2222", alu_valid, lsu_valid, out_instr);
      end
      next_cycle();
      sample();
      n_checks++; if (dut.count !== 3'd0) begin n_fail++; $display("FAIL order_drained: got %0d expected 0", dut.count); end
      next_cycle();
   endtask

   task automatic test_full();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; in_instr = 32'd100 + 32'(k); in_csig = 7'b1000000;
         sample();
         n_checks++; if (in_ready !== (k < 4)) begin n_fail++; $display("FAIL full_in_ready_%0d: got %0b expected %0b", k, in_ready, (k < 4)); end
         next_cycle();
      end
      in_valid = 1'b0;
      sample();
      n_checks++; if (dut.count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", dut.count); end
      next_cycle();
      alu_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         sample();
         n_checks++; if (alu_valid !== 1'b1 || out_instr !== 32'd100 + 32'(k)) begin
            n_fail++; $display("FAIL full_drain_%0d: got alu=%0b instr=%0d expected 1/%0d", k, alu_valid, out_instr, 100 + k);
         end
         next_cycle();
      end
   endtask

   task automatic test_drop();
      do_reset();
      for (int k = 0; k < 6; k++) begin
         in_valid = (k < 3); in_csig = 7'b0000000; in_instr = 32'(k);
         sample();
         n_checks++; if (alu_valid !== 1'b0 || lsu_valid !== 1'b0) begin n_fail++; $display("FAIL drop_no_valid_%0d: got alu=%0b lsu=%0b expected 0/0", k, alu_valid, lsu_valid); end
         next_cycle();
      end
      sample();
      n_checks++; if (drop_cnt !== 8'd3) begin n_fail++; $display("FAIL drop_cnt_3: got %0d expected 3", drop_cnt); end
      next_cycle();
      in_valid = 1'b1;
      repeat (260) next_cycle();
      in_valid = 1'b0;
      repeat (3) next_cycle();
      sample();
      n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL drop_cnt_sat: got %0d expected 255", drop_cnt); end
      next_cycle();
   endtask

   task automatic test_flush();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_instr = 32'h500 + 32'(k); in_csig = (k == 1) ? 7'b0100100 : 7'b1000000;
         next_cycle();
      end
      flush = 1'b1; in_valid = 1'b1; in_csig = 7'b1000000;
      sample();
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready_low: got %0b expected 0", in_ready); end
      next_cycle();
      flush = 1'b0; in_valid = 1'b0;
      sample();
      n_checks++; if (dut.count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", dut.count); end
      n_checks++; if (alu_valid !== 1'b0 || lsu_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valids: got alu=%0b lsu=%0b expected 0/0", alu_valid, lsu_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready_high: got %0b expected 1", in_ready); end
      n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL flush_drop_cnt: got %0d expected 0", drop_cnt); end
      next_cycle();
   endtask

`ifdef DISPATCH_BYPASS_EN
   task automatic test_bypass();
      do_reset();
      in_valid = 1'b1; in_instr = 32'h0000_5A5A; in_csig = 7'b0100100; lsu_ready = 1'b1;
      sample();
      n_checks++; if (lsu_valid !== 1'b1 || alu_valid !== 1'b0 || out_instr !== 32'h0000_5A5A) begin
         n_fail++; $display("FAIL bypass_same_cycle: got lsu=%0b alu=%0b instr=%0h expected 1/0/5a5a", lsu_valid, alu_valid, out_instr);
      end
      next_cycle();
      in_valid = 1'b0;
      sample();
      n_checks++; if (dut.count !== 3'd0 || lsu_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_count: got count=%0d lsu=%0b expected 0/0", dut.count, lsu_valid); end
      next_cycle();
   endtask
`endif

   task automatic test_random();
      int   r, rt;
      bit   have, from_in, consumed, e_rdy, e_alu, e_lsu;
      ent_t h;
      logic [CW-1:0] c;
      do_reset();
      mq.delete();
      mdrop = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         rst       = ($urandom_range(0, 99) == 0);
         flush     = ($urandom_range(0, 24) == 0);
         in_valid  = ($urandom_range(0, 9) < 6);
         in_instr  = $urandom;
         alu_ready = $urandom_range(0, 1);
         lsu_ready = $urandom_range(0, 1);
         r = $urandom_range(0, 9);
         c = CW'($urandom);
         if (r < 2) c = '0;
         else if (r < 6) begin
            c = c & 7'b1110011;
            if (c == 0) c = 7'b1000000;
         end else c[2] = 1'b1;
         in_csig = c;

         e_rdy   = (mq.size() != DEPTH) && !flush;
         have    = (mq.size() > 0);
         from_in = 1'b0;
         if (have) h = mq[0];
`ifdef DISPATCH_BYPASS_EN
         else if (in_valid && !flush) begin
            have = 1'b1; from_in = 1'b1; h.i = in_instr; h.c = in_csig;
         end
`endif
         rt    = have ? route(h.c) : 0;
         e_alu = have && (rt == 1);
         e_lsu = have && (rt == 2);

         sample();
         n_checks++; if (in_ready !== e_rdy) begin n_fail++; $display("FAIL rnd_in_ready@%0d: got %0b expected %0b", cyc, in_ready, e_rdy); end
         n_checks++; if (alu_valid !== e_alu || lsu_valid !== e_lsu) begin
            n_fail++; $display("FAIL rnd_valids@%0d: got alu=%0b lsu=%0b expected %0b/%0b", cyc, alu_valid, lsu_valid, e_alu, e_lsu);
         end
         n_checks++; if (drop_cnt !== 8'(mdrop)) begin n_fail++; $display("FAIL rnd_drop_cnt@%0d: got %0d expected %0d", cyc, drop_cnt, mdrop); end
         if (e_alu || e_lsu) begin
            n_checks++; if (out_instr !== h.i || out_csig !== h.c) begin
               n_fail++; $display("FAIL rnd_head@%0d: got %0h/%0b expected %0h/%0b", cyc, out_instr, out_csig, h.i, h.c);
            end
         end

         if (rst) begin
            mq.delete(); mdrop = 0;
         end else if (flush) begin
            mq.delete();
         end else begin
            consumed = have && ((rt == 0) || (rt == 1 && alu_ready) || (rt == 2 && lsu_ready));
            if (consumed && rt == 0 && mdrop < 255) mdrop++;
            if (consumed && !from_in) void'(mq.pop_front());
            if (in_valid && e_rdy && !(consumed && from_in)) mq.push_back('{i: in_instr, c: in_csig});
         end
         next_cycle();
      end
      rst = 1'b0;
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_alu_dispatch();
      test_order();
      test_full();
      test_drop();
      test_flush();
`ifdef DISPATCH_BYPASS_EN
      test_bypass();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dispatch_ctrl.md
DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 Parameters SHALL be: INSTR_WIDTH, default 32, instruction width; C_SIG_WIDTH, default 7, control-signal width; DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  discards all queued entries.
REQ-005 in_valid  input  1  decoded instruction offered.
REQ-006 in_ready  output  1  queue can accept this cycle.
REQ-007 in_instr  input  INSTR_WIDTH  raw instruction.
REQ-008 in_csig  input  C_SIG_WIDTH  control signals from the decoder.
REQ-009 alu_valid / alu_ready  output / input  1 each  ALU reservation-station handshake.
REQ-010 lsu_valid / lsu_ready  output / input  1 each  load/store-queue handshake.
REQ-011 out_instr, out_csig  output  INSTR_WIDTH, C_SIG_WIDTH  head entry, shared by both targets.
REQ-012 drop_cnt  output  8  count of discarded all-zero control words.

Function
REQ-013 Queue SHALL be circular, DEPTH entries of {instr, csig}, with head/tail pointers and an occupancy count 0..DEPTH.
REQ-014 in_ready SHALL equal (count != DEPTH) && !flush; a push SHALL occur when in_valid && in_ready.
REQ-015 A full queue SHALL NOT accept in the same cycle as a pop; in_ready depends only on registered count and flush.
REQ-016 Routing of head csig: csig[3]|csig[2] -> LSU; else csig != 0 -> ALU; csig == 0 -> drop.
REQ-017 alu_valid SHALL be 1 iff count>0 and head routes to ALU; lsu_valid likewise for LSU; never both.
REQ-018 Pop SHALL occur on (alu_valid&&alu_ready) || (lsu_valid&&lsu_ready) || (count>0 && head routes to drop); at most one pop per cycle.
REQ-019 Dispatch SHALL be strictly in order; a head blocked by its not-ready target stalls all younger entries.
REQ-020 A dropped head SHALL be popped in one cycle with no valid asserted, and drop_cnt SHALL increment, saturating at 255.
REQ-021 Simultaneous push and pop (count < DEPTH) SHALL leave count unchanged and advance both pointers.
REQ-022 Pointers SHALL wrap modulo DEPTH.
REQ-023 Latency without bypass: an entry pushed in cycle N into an empty queue SHALL be presented in cycle N+1.
REQ-024 out_instr/out_csig SHALL show the head entry whenever count>0; value is don't-care otherwise.
REQ-025 flush SHALL set count, head, and tail to 0 at the next edge, suppress any push that cycle, and leave drop_cnt unchanged; any handshake completing in the flush cycle is still treated as dispatched by the target.
REQ-026 valid SHALL NOT drop while ready is low, except on flush or rst.

Reset
REQ-027 On rst: count=0, head=tail=0, drop_cnt=0; alu_valid=lsu_valid=0 and in_ready=1 in the following cycle.
REQ-028 rst SHALL take priority over flush, push, and pop in the same cycle; queue contents need not be cleared.

Configuration
REQ-029 Macro DISPATCH_BYPASS_EN: when defined, with count==0 and in_valid, the incoming entry SHALL be routed combinationally to the outputs. If its target is ready, it SHALL dispatch in the same cycle without being enqueued; a zero csig SHALL be dropped in the same cycle. Otherwise it SHALL be enqueued normally.
REQ-030 Without DISPATCH_BYPASS_EN, no combinational path SHALL exist from in_* to alu_valid, lsu_valid, or out_*; latency per REQ-023.

Verification
REQ-031 Reset, then push csig 7'b1000000, alu_ready=1 -> alu_valid=1 next cycle, count returns to 0; lsu_valid stays 0.
REQ-032 Push LW 7'b1101010 then R-type 7'b1000000, lsu_ready=0, alu_ready=1 for 3 cycles -> lsu_valid held; no ALU dispatch; order preserved after lsu_ready=1.
REQ-033 Push 5 entries with both readies 0, DEPTH=4 -> in_ready=0 after the 4th push; 5th held by source; count=4.
REQ-034 Push 7'b0000000 three times -> drop_cnt=3, no valid asserted; 260 drops -> drop_cnt=255.
REQ-035 Queue holding 3 entries, assert flush with in_valid=1 -> next cycle count=0, valids 0, in_ready=1.
REQ-036 With DISPATCH_BYPASS_EN and empty queue, SW 7'b0100100 with lsu_ready=1 -> lsu_valid=1 in the same cycle; count stays 0.
